// File: rtl/nes_reset_seq_if.sv
// nes_reset_seq_if
//   Groups the PLL lock input and the reset / clock-enable outputs of the NES
//   reset sequencer into one bundle.
//   master : the sequencer (reads pll_locked, drives everything else)
//   slave  : the system side (drives pll_locked, consumes resets and enables)
// Signals
//   pll_locked     1  PLL LOCK flag, asynchronous to clk
//   sys_reset      1  active-high reset for memories/PPU/bus
//   cpu_reset      1  active-high reset for the CPU
//   ppu_ce         1  single-cycle PPU clock enable
//   cpu_ce         1  single-cycle CPU clock enable, coincident with a ppu_ce
//   running        1  high only once the full sequence has completed
//   lock_loss_cnt  8  saturating lock-loss event count
//                     (present only when NES_RESET_SEQ_LOSS_CNT_EN is defined)
interface nes_reset_seq_if;
  logic       pll_locked;
  logic       sys_reset;
  logic       cpu_reset;
  logic       ppu_ce;
  logic       cpu_ce;
  logic       running;
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  modport master (
    input  pll_locked,
    output sys_reset, cpu_reset, ppu_ce, cpu_ce, running
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
    , output lock_loss_cnt
`endif
  );

  modport slave (
    output pll_locked,
    input  sys_reset, cpu_reset, ppu_ce, cpu_ce, running
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
    , input lock_loss_cnt
`endif
  );
endinterface

// File: rtl/nes_reset_seq.sv
// nes_reset_seq
//   Reset sequencer and clock-enable generator for the NES core. Waits for the
//   PLL lock flag to be stable for STABLE_CYCLES clocks, releases sys_reset,
//   waits CPU_DELAY more clocks, then releases cpu_reset. PPU/CPU clock enables
//   run from the moment sys_reset drops. Any loss of lock returns to reset.
// Optional feature macro: NES_RESET_SEQ_LOSS_CNT_EN adds the saturating
//   lock_loss_cnt output; without it the port and counter are absent.
// Ports
//   clk    in  system clock (PLL output)
//   reset  in  synchronous, active-high reset
//   bus    nes_reset_seq_if.master (pll_locked in; resets, enables, running out)
// Parameters
//   STABLE_CYCLES  cycles lock must stay high before sys_reset release (>=2)
//   CPU_DELAY      cycles from sys_reset release to cpu_reset release (>=1)
//   PPU_DIV        clk cycles per ppu_ce pulse (>=2)
//   CPU_RATIO      ppu_ce pulses per cpu_ce pulse (>=1)
module nes_reset_seq #(
  parameter int STABLE_CYCLES = 65536,
  parameter int CPU_DELAY     = 16,
  parameter int PPU_DIV       = 4,
  parameter int CPU_RATIO     = 3
) (
  input logic             clk,
  input logic             reset,
  nes_reset_seq_if.master bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > CPU_DELAY) ? STABLE_CYCLES : CPU_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int DIV_W   = $clog2(PPU_DIV);
  localparam int RAT_W   = (CPU_RATIO > 1) ? $clog2(CPU_RATIO) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(PPU_DIV - 1);
  localparam logic [RAT_W-1:0] RAT_LAST    = RAT_W'(CPU_RATIO - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    MEM_RUN,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             sys_reset_q;
  logic             cpu_reset_q;
  logic             running_q;
  logic             ce_active;
  logic [DIV_W-1:0] div_cnt;
  logic [RAT_W-1:0] ratio_cnt;
  logic             ppu_hit;
  logic             cpu_hit;

  // Two-flop synchroniser bringing the asynchronous LOCK flag into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // ce_active is a registered copy of "state is MEM_RUN or RUN", so the
  // enables drop in the very cycle the FSM leaves those states.
  assign ppu_hit = ce_active && (div_cnt == DIV_LAST);
  assign cpu_hit = ppu_hit && (ratio_cnt == RAT_LAST);

  // Sequencer FSM. Outputs are registered together with the state they
  // belong to. Lock loss is tested before count completion so a simultaneous
  // loss always wins. The enable dividers live here too, because they are
  // advanced and cleared by exactly the same state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      ce_active   <= 1'b0;
      div_cnt     <= '0;
      ratio_cnt   <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lock_s) begin
            state <= STABLE;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= MEM_RUN;
            cnt         <= '0;
            sys_reset_q <= 1'b0;
            ce_active   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        MEM_RUN, RUN: begin
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_reset_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            ce_active   <= 1'b0;
            div_cnt     <= '0;
            ratio_cnt   <= '0;
          end else begin
            // Dividers keep counting across MEM_RUN -> RUN so the enable
            // phase is continuous.
            if (ppu_hit) begin
              div_cnt   <= '0;
              ratio_cnt <= cpu_hit ? '0 : ratio_cnt + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (state == MEM_RUN) begin
              if (cnt == CPU_LAST) begin
                state       <= RUN;
                cnt         <= '0;
                cpu_reset_q <= 1'b0;
                running_q   <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign bus.sys_reset = sys_reset_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.running   = running_q;
  assign bus.ppu_ce    = ppu_hit;
  assign bus.cpu_ce    = cpu_hit;

`ifdef NES_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  // Counts departures from MEM_RUN/RUN caused by lock loss; saturates at 255
  // and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_cnt <= 8'd0;
    end else if ((state == MEM_RUN || state == RUN) && !lock_s && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt;
`endif

endmodule

// File: tb/tb_nes_reset_seq.sv
// tb_nes_reset_seq
//   Self-checking bench for nes_reset_seq with STABLE_CYCLES=8, CPU_DELAY=4,
//   PPU_DIV=4, CPU_RATIO=3. A fixed vector table covers reset and the first
//   lock sequence; hand-written sequences cover the lock glitch, lock loss in
//   RUN, reset during MEM_RUN and (with NES_RESET_SEQ_LOSS_CNT_EN) counter
//   saturation; a randomized run is compared against a behavioural model.
module tb_nes_reset_seq;

  localparam int S    = 8;
  localparam int D    = 4;
  localparam int PDIV = 4;
  localparam int CRAT = 3;

  logic clk = 1'b0;
  logic reset;

  nes_reset_seq_if dut_if ();

  nes_reset_seq #(
    .STABLE_CYCLES(S),
    .CPU_DELAY    (D),
    .PPU_DIV      (PDIV),
    .CPU_RATIO    (CRAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sys;
    logic cpu;
    logic ppu;
    logic cce;
    logic run;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic pl;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model: lock is seen two edges late; "seq" is the number of
  // edges spent locked since leaving the waiting condition. The phase of
  // the sequence and of both enables follows from seq by plain arithmetic.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  bit   m_waiting = 1'b1;
  int   m_seq = 0;
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
  int   m_loss = 0;
`endif

  function automatic void model_edge(input logic r, input logic pl);
    logic ls;
    if (r) begin
      m_s1      = 1'b0;
      m_s2      = 1'b0;
      m_waiting = 1'b1;
      m_seq     = 0;
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
      m_loss    = 0;
`endif
    end else begin
      ls = m_s2;
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
      if (!m_waiting && m_seq >= S && !ls && m_loss < 255) m_loss = m_loss + 1;
`endif
      if (!ls) begin
        m_waiting = 1'b1;
      end else if (m_waiting) begin
        m_waiting = 1'b0;
        m_seq     = 0;
      end else begin
        m_seq = m_seq + 1;
      end
      m_s2 = m_s1;
      m_s1 = pl;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   act;
    int   k;
    act   = !m_waiting && (m_seq >= S);
    k     = m_seq - S + 1;
    e.sys = m_waiting || (m_seq < S);
    e.cpu = m_waiting || (m_seq < S + D);
    e.run = !m_waiting && (m_seq >= S + D);
    e.ppu = act && (k % PDIV == 0);
    e.cce = act && (k % (PDIV * CRAT) == 0);
    return e;
  endfunction

  task automatic compare_bit(input string name, input string field, input logic got, input logic want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: %s got %0b expected %0b", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    compare_bit(name, "sys_reset", dut_if.sys_reset, e.sys);
    compare_bit(name, "cpu_reset", dut_if.cpu_reset, e.cpu);
    compare_bit(name, "ppu_ce",    dut_if.ppu_ce,    e.ppu);
    compare_bit(name, "cpu_ce",    dut_if.cpu_ce,    e.cce);
    compare_bit(name, "running",   dut_if.running,   e.run);
  endtask

`ifdef NES_RESET_SEQ_LOSS_CNT_EN
  task automatic check_loss(input string name, input int want);
    n_compared++;
    if (int'(dut_if.lock_loss_cnt) != want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: lock_loss_cnt got %0d expected %0d", name, dut_if.lock_loss_cnt, want);
    end
  endtask
`endif

  // Drive one cycle of inputs, advance the model on the same edge, and
  // leave the bench 1 time unit after the edge for sampling.
  task automatic applyStimulus(input logic r, input logic pl);
    reset             = r;
    dut_if.pll_locked = pl;
    @(posedge clk);
    model_edge(r, pl);
    #1;
  endtask

  function automatic void add_vec(input logic r, input logic pl, input logic sys, input logic cpu,
                                  input logic ppu, input logic cce, input logic run);
    vec_t v;
    v.rst     = r;
    v.pl      = pl;
    v.exp.sys = sys;
    v.exp.cpu = cpu;
    v.exp.ppu = ppu;
    v.exp.cce = cce;
    v.exp.run = run;
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t e;
    logic pl;
    logic r;

    reset             = 1'b1;
    dut_if.pll_locked = 1'b0;

    // Reset for 3 cycles, then lock from edge 1: sys_reset falls after
    // edge 11, cpu_reset after edge 15, ppu_ce every 4th cycle from edge 14,
    // cpu_ce first at edge 22.
    for (int i = 0; i < 3; i++)  add_vec(1, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add_vec(0, 1, 1, 1, 0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 1, 1, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 1, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 1, 1, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pl);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Lock loss in RUN: two edges of synchroniser latency, then back to
    // WAIT_LOCK with resets asserted and enables cleared.
    applyStimulus(0, 0);
    checkOutput("loss_edge1", model_out());
    applyStimulus(0, 0);
    compare_bit("loss_edge2", "running", dut_if.running, 1'b1);
    applyStimulus(0, 0);
    checkOutput("loss_edge3", 5'b11000);
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
    check_loss("loss_count_one", 1);
`endif

    // One-cycle lock glitch during STABLE restarts the full stabilise
    // window: sys_reset stays high through edge 16 and falls at edge 17.
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    for (int ed = 1; ed <= 20; ed++) begin
      applyStimulus(0, (ed == 6) ? 1'b0 : 1'b1);
      compare_bit($sformatf("glitch_e%0d", ed), "sys_reset", dut_if.sys_reset, (ed >= 17) ? 1'b0 : 1'b1);
      checkOutput($sformatf("glitch_model_e%0d", ed), model_out());
    end

    // Reset asserted in MEM_RUN with lock held, then released: sync refill
    // delays the sys_reset fall to the 11th edge after release.
    applyStimulus(1, 0);
    for (int ed = 1; ed <= 12; ed++) applyStimulus(0, 1);
    compare_bit("memrun_reached", "sys_reset", dut_if.sys_reset, 1'b0);
    applyStimulus(1, 1);
    checkOutput("memrun_reset", 5'b11000);
    for (int ed = 1; ed <= 12; ed++) begin
      applyStimulus(0, 1);
      compare_bit($sformatf("rerun_e%0d", ed), "sys_reset", dut_if.sys_reset, (ed >= 11) ? 1'b0 : 1'b1);
    end

`ifdef NES_RESET_SEQ_LOSS_CNT_EN
    // 300 lock-loss events from RUN: counter climbs and saturates at 255.
    applyStimulus(1, 0);
    check_loss("loss_after_reset", 0);
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 16; c++) applyStimulus(0, 1);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0);
      if (n % 50 == 0 || n >= 254) check_loss($sformatf("loss_evt%0d", n), m_loss);
    end
    check_loss("loss_saturated", 255);
`endif

    // Randomised run against the model.
    applyStimulus(1, 0);
    pl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) pl = ~pl;
      r = ($urandom_range(0, 99) == 0);
      applyStimulus(r, pl);
      e = model_out();
      checkOutput($sformatf("rand%0d", c), e);
`ifdef NES_RESET_SEQ_LOSS_CNT_EN
      check_loss($sformatf("rand_loss%0d", c), m_loss);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
